// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use detection
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic        ALUSrc_i,
  input  logic        RegDst_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        MemtoReg_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_RDaddr_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RDaddr_i,
  input  logic [31:0] MEMWB_data_i,
  output logic        valid_o,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [2:0]  ALUCtrl_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  WBaddr_o,
  output logic        RegWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic        loaduse_o
);
  logic        valid_q, alu_src_q, reg_dst_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [2:0]  alu_ctrl_q;
  logic [31:0] fwd_a, fwd_b;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q      <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= '0;
    end else if (!stall_i) begin
      valid_q      <= valid_i;
      alu_src_q    <= valid_i & ALUSrc_i;
      reg_dst_q    <= valid_i & RegDst_i;
      reg_write_q  <= valid_i & RegWrite_i;
      mem_read_q   <= valid_i & MemRead_i;
      mem_write_q  <= valid_i & MemWrite_i;
      mem_to_reg_q <= valid_i & MemtoReg_i;
      rs_data_q    <= RSdata_i;
      rt_data_q    <= RTdata_i;
      imm_q        <= imm_i;
      rs_q         <= RSaddr_i;
      rt_q         <= RTaddr_i;
      rd_q         <= RDaddr_i;
      alu_ctrl_q   <= ALUCtrl_i;
    end
  end
  always_comb begin
    fwd_a = (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == rs_q) ? EXMEM_data_i :
            (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == rs_q) ? MEMWB_data_i : rs_data_q;
    fwd_b = (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == rt_q) ? EXMEM_data_i :
            (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == rt_q) ? MEMWB_data_i : rt_data_q;
  end
  assign valid_o      = valid_q;
  assign data1_o      = fwd_a;
  assign data2_o      = alu_src_q ? imm_q : fwd_b;
  assign store_data_o = fwd_b;
  assign ALUCtrl_o    = alu_ctrl_q;
  assign WBaddr_o     = reg_dst_q ? rd_q : rt_q;
  assign RegWrite_o   = valid_q & reg_write_q;
  assign MemRead_o    = valid_q & mem_read_q;
  assign MemWrite_o   = valid_q & mem_write_q;
  assign MemtoReg_o   = valid_q & mem_to_reg_q;
  assign loaduse_o    = MemRead_o && WBaddr_o != 5'd0 && (WBaddr_o == RSaddr_i || WBaddr_o == RTaddr_i);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector self-checking bench for id_ex_stage
module tb_id_ex_stage;
  logic        clk_i = 1'b0, rst_i, stall_i, flush_i, valid_i;
  logic [31:0] RSdata_i, RTdata_i, imm_i, EXMEM_data_i, MEMWB_data_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, EXMEM_RDaddr_i, MEMWB_RDaddr_i;
  logic [2:0]  ALUCtrl_i;
  logic        ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
  logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic        valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, loaduse_o;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  ALUCtrl_o;
  logic [4:0]  WBaddr_o;
  int n_chk = 0, n_fail = 0;
  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .ALUCtrl_i(ALUCtrl_i),
    .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i), .EXMEM_data_i(EXMEM_data_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
    .store_data_o(store_data_o), .WBaddr_o(WBaddr_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o), .loaduse_o(loaduse_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    rst_i = 0; stall_i = 0; flush_i = 0; valid_i = 0;
    RSdata_i = 0; RTdata_i = 0; imm_i = 0; RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0; ALUCtrl_i = 0;
    ALUSrc_i = 0; RegDst_i = 0; RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0;
    EXMEM_RegWrite_i = 0; EXMEM_RDaddr_i = 0; EXMEM_data_i = 0;
    MEMWB_RegWrite_i = 0; MEMWB_RDaddr_i = 0; MEMWB_data_i = 0;
  endtask
  task automatic randomize_inputs();
    valid_i = 1'($urandom); RSdata_i = $urandom; RTdata_i = $urandom; imm_i = $urandom;
    RSaddr_i = 5'($urandom); RTaddr_i = 5'($urandom); RDaddr_i = 5'($urandom); ALUCtrl_i = 3'($urandom);
    ALUSrc_i = 1'($urandom); RegDst_i = 1'($urandom); RegWrite_i = 1'($urandom);
    MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
    EXMEM_RegWrite_i = 1'($urandom); EXMEM_RDaddr_i = 5'($urandom); EXMEM_data_i = $urandom;
    MEMWB_RegWrite_i = 1'($urandom); MEMWB_RDaddr_i = 5'($urandom); MEMWB_data_i = $urandom;
  endtask
  initial begin
    idle();
    randomize_inputs();
    rst_i = 1; stall_i = 1'($urandom); flush_i = 1'($urandom);
    tick();
    randomize_inputs();
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_data1", data1_o, 0);
    chk("rst_data2", data2_o, 0);
    chk("rst_store", store_data_o, 0);
    chk("rst_aluctrl", ALUCtrl_o, 0);
    chk("rst_wbaddr", WBaddr_o, 0);
    chk("rst_ctrl", {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 0);
    chk("rst_loaduse", loaduse_o, 0);
    idle();
    valid_i = 1; RSdata_i = 5; RTdata_i = 7; ALUCtrl_i = 3'b010; RSaddr_i = 1; RTaddr_i = 2; RDaddr_i = 3;
    RegDst_i = 1; RegWrite_i = 1;
    tick();
    chk("load_data1", data1_o, 5);
    chk("load_data2", data2_o, 7);
    chk("load_store", store_data_o, 7);
    chk("load_aluctrl", ALUCtrl_o, 3'b010);
    chk("load_valid", valid_o, 1);
    chk("load_wbaddr", WBaddr_o, 3);
    chk("load_regwrite", RegWrite_o, 1);
    idle();
    valid_i = 1; RSaddr_i = 3; RSdata_i = 32'h11;
    tick();
    EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 3; EXMEM_data_i = 32'hAA;
    MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 3; MEMWB_data_i = 32'hBB;
    #1 chk("fwd_exmem", data1_o, 32'hAA);
    EXMEM_RegWrite_i = 0;
    #1 chk("fwd_memwb", data1_o, 32'hBB);
    EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 0; MEMWB_RDaddr_i = 0;
    #1 chk("fwd_r0", data1_o, 32'h11);
    idle();
    valid_i = 1; ALUSrc_i = 1; imm_i = 32'hFFFFFFFC; RTaddr_i = 6; RTdata_i = 32'h99;
    tick();
    EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 6; EXMEM_data_i = 32'h1234;
    #1 chk("alusrc_data2", data2_o, 32'hFFFFFFFC);
    chk("alusrc_store", store_data_o, 32'h1234);
    idle();
    valid_i = 1; MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1; RegDst_i = 0; RTaddr_i = 4; RDaddr_i = 9;
    RSdata_i = 32'h77;
    tick();
    chk("lw_wbaddr", WBaddr_o, 4);
    chk("lw_memread", MemRead_o, 1);
    RSaddr_i = 5; RTaddr_i = 5;
    #1 chk("lu_nohit", loaduse_o, 0);
    RTaddr_i = 4;
    #1 chk("lu_rt", loaduse_o, 1);
    RSaddr_i = 4; RTaddr_i = 5;
    #1 chk("lu_rs", loaduse_o, 1);
    flush_i = 1;
    tick();
    chk("flush_valid", valid_o, 0);
    chk("flush_regwrite", RegWrite_o, 0);
    chk("flush_memread", MemRead_o, 0);
    chk("flush_data1", data1_o, 0);
    chk("flush_loaduse", loaduse_o, 0);
    idle();
    MemRead_i = 1; RegWrite_i = 1; MemWrite_i = 1; MemtoReg_i = 1; RTaddr_i = 8; RSdata_i = 32'h42;
    tick();
    chk("inv_valid", valid_o, 0);
    chk("inv_ctrl", {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 0);
    chk("inv_data1", data1_o, 32'h42);
    RSaddr_i = 8;
    #1 chk("inv_loaduse", loaduse_o, 0);
    idle();
    valid_i = 1; MemRead_i = 1; RTaddr_i = 0;
    tick();
    chk("lu_r0", loaduse_o, 0);
    idle();
    valid_i = 1; RSdata_i = 32'h55; RTdata_i = 32'h66; RSaddr_i = 1; RTaddr_i = 2; RDaddr_i = 7;
    RegDst_i = 1; ALUCtrl_i = 3'b100; RegWrite_i = 1; MemWrite_i = 1;
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      RSdata_i = $urandom; RTdata_i = $urandom; imm_i = $urandom; RSaddr_i = 5'($urandom);
      RTaddr_i = 5'($urandom); RDaddr_i = 5'($urandom); ALUCtrl_i = 3'($urandom); ALUSrc_i = 1'($urandom);
      RegDst_i = 1'($urandom); MemRead_i = 1'($urandom); valid_i = 1'($urandom);
      tick();
      chk("stall_data1", data1_o, 32'h55);
      chk("stall_data2", data2_o, 32'h66);
      chk("stall_aluctrl", ALUCtrl_o, 3'b100);
      chk("stall_wbaddr", WBaddr_o, 7);
      chk("stall_ctrl", {valid_o, RegWrite_o, MemRead_o, MemWrite_o}, 4'b1101);
    end
    flush_i = 1;
    tick();
    chk("stflush_valid", valid_o, 0);
    chk("stflush_data1", data1_o, 0);
    chk("stflush_ctrl", {RegWrite_o, MemWrite_o}, 0);
    idle();
    valid_i = 1; RSdata_i = 32'hDEAD; RegWrite_i = 1;
    tick();
    chk("pre_rst_valid", valid_o, 1);
    rst_i = 1; stall_i = 1;
    tick();
    chk("midrst_valid", valid_o, 0);
    chk("midrst_data1", data1_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
